neuron_mac: RTL and testbench

Sequential multiply-accumulate neuron for the MNIST 126-126-10 MLP. It consumes one signed activation per accepted cycle, multiplies it by the matching weight from an internal writable weight memory, and accumulates over `numWeight` inputs. It optionally adds a bias, then presents the full-width signed sum with a one-cycle valid strobe. The result feeds the ReLU stage directly, using the same sum width.

---
 rtl/mlp_pkg.sv | 9 +
 rtl/neuron_weight_mem.sv | 28 ++
 rtl/neuron_mac.sv | 148 ++++++++++++++
 tb/tb_neuron_mac.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared numeric formats for the MNIST MLP datapath: word widths and the full-width neuron sum type.
package mlp_pkg;
    localparam int DATA_W    = 16;
    localparam int W_INT_W   = 4;
    localparam int INT_EXT_W = 10;
    localparam int SUM_W     = 2*DATA_W + INT_EXT_W;

    typedef logic signed [SUM_W-1:0] sum_t;
endpackage

// File: rtl/neuron_weight_mem.sv
// Neuron weight store: depth x width, one synchronous read port, one write port, no reset.
// Latency: rd_data valid one edge after rd_en; same-address read/write returns the old word.
// Backpressure: none, both ports accept every cycle.
module neuron_weight_mem #(
    parameter int depth  = 126,
    parameter int width  = 16,
    parameter int addr_w = $clog2(depth)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [addr_w-1:0] wr_addr,
    input  logic [width-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [addr_w-1:0] rd_addr,
    output logic [width-1:0]  rd_data
);

    logic [width-1:0] mem [depth];

    // Read and write share the edge; the non-blocking read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < addr_w'(depth)))
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/neuron_mac.sv
// Sequential MAC neuron: sum of numWeight activation*weight products, plus bias when NEURON_BIAS_EN is defined.
// Latency: last input sampled at edge k -> out_sum/out_valid registered at edge k+3, one-cycle strobe.
// Backpressure: none, every in_valid cycle is accepted; idle gaps hold idx and acc.
module neuron_mac
    import mlp_pkg::*;
#(
    parameter int dataWidth      = DATA_W,
    parameter int weightIntWidth = W_INT_W,
    parameter int IntWidthExtend = INT_EXT_W,
    parameter int numWeight      = 126
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_valid,
    input  logic signed [dataWidth-1:0]                 in_data,
    input  logic                                        weight_wr_en,
    input  logic [$clog2(numWeight)-1:0]                weight_wr_addr,
    input  logic signed [dataWidth-1:0]                 weight_wr_data,
`ifdef NEURON_BIAS_EN
    input  logic                                        bias_wr_en,
    input  logic signed [dataWidth-1:0]                 bias_wr_data,
`endif
    output logic                                        out_valid,
    output logic signed [2*dataWidth+IntWidthExtend-1:0] out_sum
);

    localparam int AW = $clog2(numWeight);
    localparam int PW = 2*dataWidth;
    localparam int SW = 2*dataWidth + IntWidthExtend;

    if (numWeight < 2 || numWeight > (1 << IntWidthExtend) ||
        weightIntWidth < 1 || weightIntWidth > dataWidth) begin : g_cfg_err
        $error("neuron_mac: unsupported parameter combination");
    end

    logic [AW-1:0]                idx;
    logic                         f_vld, f_last;
    logic signed [dataWidth-1:0]  f_x;
    logic [dataWidth-1:0]         rd_data;
    logic                         s0_vld, s0_last;
    logic signed [dataWidth-1:0]  s0_x, s0_w;
    logic                         s1_vld, s1_last;
    logic signed [PW-1:0]         s1_prod;
    logic signed [SW-1:0]         acc;
    logic signed [SW-1:0]         prod_ext;
    logic signed [SW-1:0]         frame_sum;

    neuron_weight_mem #(
        .depth (numWeight),
        .width (dataWidth)
    ) u_wmem (
        .clk     (clk),
        .wr_en   (weight_wr_en),
        .wr_addr (weight_wr_addr),
        .wr_data (weight_wr_data),
        .rd_en   (in_valid),
        .rd_addr (idx),
        .rd_data (rd_data)
    );

    // Fetch: index counter plus activation aligned with the memory's read register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx    <= '0;
            f_vld  <= 1'b0;
            f_last <= 1'b0;
            f_x    <= '0;
        end else begin
            f_vld <= in_valid;
            if (in_valid) begin
                f_x    <= in_data;
                f_last <= (idx == AW'(numWeight-1));
                idx    <= (idx == AW'(numWeight-1)) ? '0 : idx + AW'(1);
            end
        end
    end

    // S0 captures the operand pair, S1 the full-precision product.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_vld  <= 1'b0;
            s0_last <= 1'b0;
            s0_x    <= '0;
            s0_w    <= '0;
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_prod <= '0;
        end else begin
            s0_vld  <= f_vld;
            s1_vld  <= s0_vld;
            if (f_vld) begin
                s0_x    <= f_x;
                s0_w    <= rd_data;
                s0_last <= f_last;
            end
            if (s0_vld) begin
                s1_prod <= PW'(s0_x) * PW'(s0_w);
                s1_last <= s0_last;
            end
        end
    end

`ifdef NEURON_BIAS_EN
    logic signed [dataWidth-1:0] bias;
    logic signed [SW-1:0]        bias_ext;

    always_ff @(posedge clk) begin
        if (!rst_n)
            bias <= '0;
        else if (bias_wr_en)
            bias <= bias_wr_data;
    end

    // Weight-format bias moved onto the product's fraction point.
    always_comb begin
        bias_ext = SW'(bias) <<< (dataWidth-1);
    end
`endif

    always_comb begin
        prod_ext = SW'(s1_prod);
`ifdef NEURON_BIAS_EN
        frame_sum = acc + prod_ext + bias_ext;
`else
        frame_sum = acc + prod_ext;
`endif
    end

    // S2: accumulate, or close the frame and clear acc for a back-to-back successor.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc       <= '0;
            out_sum   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= s1_vld && s1_last;
            if (s1_vld) begin
                if (s1_last) begin
                    out_sum <= frame_sum;
                    acc     <= '0;
                end else begin
                    acc <= acc + prod_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: hand-computed frame sums, strobe counts and strobe latency.
module tb_neuron_mac;
    import mlp_pkg::*;

    localparam int NW = 126;
    localparam int AW = $clog2(NW);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [15:0]       in_data = '0;
    logic              weight_wr_en = 1'b0;
    logic [AW-1:0]     weight_wr_addr = '0;
    logic [15:0]       weight_wr_data = '0;
    logic              bias_wr_en = 1'b0;
    logic [15:0]       bias_wr_data = '0;
    logic              out_valid;
    logic [SUM_W-1:0]  out_sum;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   last_edge = 0;
    sum_t strobe_sum[$];
    int   strobe_cyc[$];

    localparam sum_t FULL_HALF = 42'h1F8000000;
    localparam sum_t FULL_QTR  = 42'h0FC000000;
    localparam sum_t NEG_SUM   = sum_t'(-(64'sd63 * 64'sd134217728));
    localparam sum_t RELOAD    = 42'h1F4000000;
`ifdef NEURON_BIAS_EN
    localparam sum_t BIAS_SUM  = 42'h1FA000000;
`else
    localparam sum_t BIAS_SUM  = 42'h1F8000000;
`endif

    neuron_mac dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .weight_wr_en   (weight_wr_en),
        .weight_wr_addr (weight_wr_addr),
        .weight_wr_data (weight_wr_data),
`ifdef NEURON_BIAS_EN
        .bias_wr_en     (bias_wr_en),
        .bias_wr_data   (bias_wr_data),
`endif
        .out_valid      (out_valid),
        .out_sum        (out_sum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            strobe_sum.push_back(sum_t'(out_sum));
            strobe_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input sum_t obs, input sum_t exp);
        n_chk++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_w(input int addr, input logic [15:0] data);
        weight_wr_en   = 1'b1;
        weight_wr_addr = AW'(addr);
        weight_wr_data = data;
        tick();
        weight_wr_en   = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] data);
        for (int i = 0; i < NW; i++) write_w(i, data);
    endtask

    task automatic write_bias(input logic [15:0] data);
        bias_wr_en   = 1'b1;
        bias_wr_data = data;
        tick();
        bias_wr_en   = 1'b0;
    endtask

    task automatic send(input logic [15:0] x);
        in_valid = 1'b1;
        in_data  = x;
        tick();
        last_edge = cyc;
        in_valid = 1'b0;
    endtask

    task automatic frame(input logic [15:0] x, input bit gaps);
        for (int i = 0; i < NW; i++) begin
            send(x);
            if (gaps) repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic drain();
        repeat (8) tick();
    endtask

    task automatic clear_log();
        strobe_sum.delete();
        strobe_cyc.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) tick();
        check("reset_out_valid", sum_t'(out_valid), sum_t'(0));
        check("reset_out_sum", sum_t'(out_sum), sum_t'(0));
        rst_n = 1'b1;
        tick();

        // All-ones frame, bias 0.25 where the bias path exists.
        load_all(16'h1000);
        write_bias(16'h0400);
        clear_log();
        frame(16'h4000, 1'b0);
        drain();
        check("ones_count", sum_t'(strobe_sum.size()), sum_t'(1));
        check("ones_sum", strobe_sum[0], BIAS_SUM);
        check("ones_latency", sum_t'(strobe_cyc[0] - last_edge), sum_t'(3));

        // Negative weights, bias back to zero.
        write_bias(16'h0000);
        load_all(16'hF000);
        clear_log();
        frame(16'h4000, 1'b0);
        drain();
        check("neg_count", sum_t'(strobe_sum.size()), sum_t'(1));
        check("neg_sum", strobe_sum[0], NEG_SUM);

        // Back-to-back frames with no idle cycle between them.
        load_all(16'h1000);
        clear_log();
        frame(16'h4000, 1'b0);
        frame(16'h2000, 1'b0);
        drain();
        check("b2b_count", sum_t'(strobe_sum.size()), sum_t'(2));
        check("b2b_sum0", strobe_sum[0], FULL_HALF);
        check("b2b_sum1", strobe_sum[1], FULL_QTR);
        check("b2b_spacing", sum_t'(strobe_cyc[1] - strobe_cyc[0]), sum_t'(NW));

        // Random idle cycles inside a frame.
        clear_log();
        frame(16'h4000, 1'b1);
        drain();
        check("gap_count", sum_t'(strobe_sum.size()), sum_t'(1));
        check("gap_sum", strobe_sum[0], FULL_HALF);
        check("gap_latency", sum_t'(strobe_cyc[0] - last_edge), sum_t'(3));

        // Reset after 60 inputs discards the partial frame.
        clear_log();
        for (int i = 0; i < 60; i++) send(16'h4000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        frame(16'h4000, 1'b0);
        drain();
        check("rst_count", sum_t'(strobe_sum.size()), sum_t'(1));
        check("rst_sum", strobe_sum[0], FULL_HALF);
        check("rst_latency", sum_t'(strobe_cyc[0] - last_edge), sum_t'(3));

        // Zeroing weight[5] between frames removes exactly one product.
        write_w(5, 16'h0000);
        clear_log();
        frame(16'h4000, 1'b0);
        drain();
        check("reload_count", sum_t'(strobe_sum.size()), sum_t'(1));
        check("reload_sum", strobe_sum[0], RELOAD);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
